// File: rtl/round_sat_rr_scheduler_pkg.sv
// rtl/round_sat_rr_scheduler_pkg.sv - shared types, defaults and round-robin pick helper
// for the round/saturate scheduler.
package round_sat_pkg;

   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_OUT_WIDTH = 16;
   localparam int CH_ID_W       = $clog2(DEF_NUM_CH);
   localparam int MAX_CH        = 64;

   typedef logic [CH_ID_W-1:0] ch_id_t;

   typedef struct packed {
      logic [DEF_OUT_WIDTH-1:0] data;
      logic                     ovf;
      logic                     unf;
   } round_sat_res_t;

   // First set bit of full_vec at or after ptr, wrapping modulo n; -1 when none is set.
   function automatic int rr_pick(input logic [MAX_CH-1:0] full_vec, input int ptr, input int n);
      int pick;
      int idx;
      pick = -1;
      for (int k = 0; k < MAX_CH; k++) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (pick < 0 && full_vec[idx[5:0]]) pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/round_sat_rr_scheduler_unit.sv
// rtl/round_sat_rr_scheduler_unit.sv - combinational round-half-to-even and saturate
// from a wide signed accumulator to the output format.
module round_sat_unit #(
   parameter int ACC_WIDTH = 42,
   parameter int ACC_FRAC  = 32,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_FRAC  = 15
) (
   input  logic [ACC_WIDTH-1:0] data_i,
   output logic [OUT_WIDTH-1:0] data_o,
   output logic                 ovf_o,
   output logic                 unf_o
);

   localparam int D  = ACC_FRAC - OUT_FRAC;
   localparam int RW = ACC_WIDTH - D;
   localparam int SW = RW + 1;
   localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
   localparam logic signed [SW-1:0] MIN_V = SW'(-(64'sd1 <<< (OUT_WIDTH-1)));

   logic signed [RW-1:0] raw;
   logic                 inc;
   logic signed [SW-1:0] sum;

   if (D == 0) begin : g_nornd
      assign raw = $signed(data_i);
      assign inc = 1'b0;
   end else begin : g_rnd
      logic gb, rb, sb;
      assign raw = $signed(data_i[ACC_WIDTH-1:D]);
      assign gb  = data_i[D-1];
      if (D >= 2) begin : g_r
         assign rb = data_i[D-2];
      end else begin : g_nr
         assign rb = 1'b0;
      end
      if (D >= 3) begin : g_s
         assign sb = |data_i[D-3:0];
      end else begin : g_ns
         assign sb = 1'b0;
      end
      assign inc = gb & (rb | sb | raw[0]);
   end

   // One guard bit so a rounding carry out of the top never wraps before the compare.
   assign sum   = $signed({raw[RW-1], raw}) + $signed({{(SW-1){1'b0}}, inc});
   assign ovf_o = (sum > MAX_V);
   assign unf_o = (sum < MIN_V);

   always_comb begin
      data_o = sum[OUT_WIDTH-1:0];
      if (ovf_o)      data_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (unf_o) data_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   end

endmodule

// File: rtl/round_sat_rr_scheduler.sv
// rtl/round_sat_rr_scheduler.sv - per-channel holding buffers, round-robin grant into one
// shared round/sat unit, registered output with channel ID, per-channel saturation stats.
module round_sat_rr_scheduler
   import round_sat_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int ACC_WIDTH = 42,
   parameter int ACC_FRAC  = 32,
   parameter int OUT_WIDTH = 16,
   parameter int OUT_FRAC  = 15,
   parameter int CNT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH*ACC_WIDTH-1:0]    req_data_i,
   input  logic [NUM_CH-1:0]              req_valid_i,
   output logic [NUM_CH-1:0]              req_ready_o,
   output logic [OUT_WIDTH-1:0]           out_data_o,
   output logic [$clog2(NUM_CH)-1:0]      out_ch_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   input  logic                           clr_i,
   output logic [NUM_CH*CNT_WIDTH-1:0]    sat_cnt_o,
   output logic [NUM_CH-1:0]              sat_sticky_o
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]    buf_full_q, buf_full_d;
   logic [ACC_WIDTH-1:0] buf_data_q [NUM_CH];
   logic [ACC_WIDTH-1:0] buf_data_d [NUM_CH];
   logic [CH_W-1:0]      ptr_q, ptr_d;
   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]      out_ch_q, out_ch_d;
   logic [CNT_WIDTH-1:0] sat_cnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0] sat_cnt_d [NUM_CH];
   logic [NUM_CH-1:0]    sat_sticky_q, sat_sticky_d;

   logic                 advance;
   logic                 grant_any;
   int                   pick;
   logic [CH_W-1:0]      grant_ch;
   logic [ACC_WIDTH-1:0] unit_in;
   logic [OUT_WIDTH-1:0] unit_data;
   logic                 unit_ovf, unit_unf;

   always_comb begin
      advance   = !out_valid_q || out_ready_i;
      pick      = rr_pick(MAX_CH'(buf_full_q), int'(ptr_q), NUM_CH);
      grant_any = advance && (pick >= 0);
      grant_ch  = (pick >= 0) ? CH_W'(pick) : '0;
      unit_in   = buf_data_q[grant_ch];
   end

   round_sat_unit #(
      .ACC_WIDTH (ACC_WIDTH),
      .ACC_FRAC  (ACC_FRAC),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_FRAC  (OUT_FRAC)
   ) u_unit (
      .data_i (unit_in),
      .data_o (unit_data),
      .ovf_o  (unit_ovf),
      .unf_o  (unit_unf)
   );

   always_comb begin
      buf_full_d   = buf_full_q;
      buf_data_d   = buf_data_q;
      ptr_d        = ptr_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_ch_d     = out_ch_q;
      sat_cnt_d    = sat_cnt_q;
      sat_sticky_d = sat_sticky_q;

      if (clr_i) begin
         for (int i = 0; i < NUM_CH; i++) sat_cnt_d[i] = '0;
         sat_sticky_d = '0;
      end

      if (grant_any) begin
         buf_full_d[grant_ch] = 1'b0;
         out_valid_d          = 1'b1;
         out_data_d           = unit_data;
         out_ch_d             = grant_ch;
         ptr_d                = (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + 1'b1;
         // A clear in the same cycle as an event still records that event.
         if (unit_ovf || unit_unf) begin
            if (clr_i)                        sat_cnt_d[grant_ch] = CNT_WIDTH'(1);
            else if (!(&sat_cnt_q[grant_ch])) sat_cnt_d[grant_ch] = sat_cnt_q[grant_ch] + 1'b1;
            sat_sticky_d[grant_ch] = 1'b1;
         end
      end else if (advance) begin
         out_valid_d = 1'b0;
      end

      for (int i = 0; i < NUM_CH; i++) begin
         if (req_valid_i[i] && !buf_full_q[i]) begin
            buf_full_d[i] = 1'b1;
            buf_data_d[i] = req_data_i[i*ACC_WIDTH +: ACC_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_full_q   <= '0;
         ptr_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_ch_q     <= '0;
         sat_sticky_q <= '0;
         for (int i = 0; i < NUM_CH; i++) sat_cnt_q[i] <= '0;
      end else begin
         buf_full_q   <= buf_full_d;
         ptr_q        <= ptr_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_ch_q     <= out_ch_d;
         sat_sticky_q <= sat_sticky_d;
         sat_cnt_q    <= sat_cnt_d;
      end
   end

   // Payload needs no reset: an empty buffer's contents are never granted.
   always_ff @(posedge clk) begin
      buf_data_q <= buf_data_d;
   end

   assign req_ready_o  = ~buf_full_q & {NUM_CH{~rst}};
   assign out_data_o   = out_data_q;
   assign out_ch_o     = out_ch_q;
   assign out_valid_o  = out_valid_q;
   assign sat_sticky_o = sat_sticky_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      assign sat_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = sat_cnt_q[i];
   end

endmodule

// File: tb/tb_round_sat_rr_scheduler.sv
// tb/tb_round_sat_rr_scheduler.sv - self-checking bench: directed vectors, fairness,
// backpressure, clear and counter saturation, then random traffic against a reference model.
module tb_round_sat_rr_scheduler;

   localparam int NCH = 4;
   localparam int AW  = 42;
   localparam int D   = 17;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NCH*AW-1:0] req_data;
   logic [NCH-1:0]    req_valid;
   logic [NCH-1:0]    req_ready, req_ready2;
   logic [15:0]       out_data, out_data2;
   logic [1:0]        out_ch, out_ch2;
   logic              out_valid, out_valid2;
   logic              out_ready;
   logic              clr;
   logic [63:0]       sat_cnt;
   logic [11:0]       sat_cnt2;
   logic [NCH-1:0]    sticky, sticky2;

   round_sat_rr_scheduler dut (
      .clk(clk), .rst(rst), .req_data_i(req_data), .req_valid_i(req_valid),
      .req_ready_o(req_ready), .out_data_o(out_data), .out_ch_o(out_ch),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .clr_i(clr),
      .sat_cnt_o(sat_cnt), .sat_sticky_o(sticky)
   );

   round_sat_rr_scheduler #(.CNT_WIDTH(3)) dut2 (
      .clk(clk), .rst(rst), .req_data_i(req_data), .req_valid_i(req_valid),
      .req_ready_o(req_ready2), .out_data_o(out_data2), .out_ch_o(out_ch2),
      .out_valid_o(out_valid2), .out_ready_i(out_ready), .clr_i(clr),
      .sat_cnt_o(sat_cnt2), .sat_sticky_o(sticky2)
   );

   int n_pass = 0;
   int n_tot  = 0;

   bit          m_full [NCH];
   longint      m_data [NCH];
   int          m_ptr;
   bit          m_ov;
   logic [15:0] m_od;
   int          m_och;
   int          m_cnt [NCH];
   bit          m_sticky [NCH];

   typedef struct {
      int          ch;
      longint      din;
      logic [15:0] exp;
   } vec_t;
   vec_t vt [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Reference: floor-divide by 2^D, round the remainder half-to-even, then clamp.
   function automatic void mref(input longint x, output logic [15:0] y, output bit sat);
      longint scale, q, rem;
      scale = 64'sd1 <<< D;
      q = x / scale;
      if (x < 0 && q * scale != x) q = q - 1;
      rem = x - q * scale;
      if (2 * rem > scale || (2 * rem == scale && q[0])) q = q + 1;
      sat = 1'b0;
      if (q > 32767)       begin q = 32767;  sat = 1'b1; end
      else if (q < -32768) begin q = -32768; sat = 1'b1; end
      y = q[15:0];
   endfunction

   task automatic model_edge();
      bit          acc [NCH];
      bit          adv;
      int          g;
      logic [15:0] y;
      bit          sat;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_full[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
         end
         m_ptr = 0; m_ov = 0; m_od = '0; m_och = 0;
         return;
      end
      for (int i = 0; i < NCH; i++) acc[i] = req_valid[i] && !m_full[i];
      adv = !m_ov || out_ready;
      g = -1;
      if (adv)
         for (int k = 0; k < NCH; k++)
            if (g < 0 && m_full[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      if (clr)
         for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_sticky[i] = 0; end
      if (g >= 0) begin
         mref(m_data[g], y, sat);
         m_ov = 1; m_od = y; m_och = g; m_ptr = (g + 1) % NCH; m_full[g] = 0;
         if (sat) begin m_cnt[g]++; m_sticky[g] = 1; end
      end else if (adv) begin
         m_ov = 0;
      end
      for (int i = 0; i < NCH; i++)
         if (acc[i]) begin
            m_full[i] = 1;
            m_data[i] = longint'($signed(req_data[i*AW +: AW]));
         end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all();
      logic [NCH-1:0] er, es;
      for (int i = 0; i < NCH; i++) begin
         er[i] = !m_full[i] && !rst;
         es[i] = m_sticky[i];
      end
      chk("ready", 64'(req_ready), 64'(er));
      chk("ready2", 64'(req_ready2), 64'(er));
      chk("valid", 64'(out_valid), 64'(m_ov));
      chk("valid2", 64'(out_valid2), 64'(m_ov));
      chk("data", 64'(out_data), 64'(m_od));
      chk("data2", 64'(out_data2), 64'(m_od));
      chk("ch", 64'(out_ch), 64'(m_och));
      chk("ch2", 64'(out_ch2), 64'(m_och));
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("cnt%0d", i), 64'(sat_cnt[i*16 +: 16]), 64'((m_cnt[i] > 65535) ? 65535 : m_cnt[i]));
         chk($sformatf("cnt3b%0d", i), 64'(sat_cnt2[i*3 +: 3]), 64'((m_cnt[i] > 7) ? 7 : m_cnt[i]));
      end
      chk("sticky", 64'(sticky), 64'(es));
      chk("sticky2", 64'(sticky2), 64'(es));
   endtask

   task automatic set_ch(input int ch, input longint v);
      req_data[ch*AW +: AW] = v[AW-1:0];
   endtask

   function automatic longint rnd_acc();
      longint v;
      case ($urandom_range(0, 2))
         0: v = longint'($urandom_range(0, 2097151)) - 64'sd1048576;
         1: begin
            v = 64'sd4294967296 + longint'($urandom_range(0, 262143)) - 64'sd131072;
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         default: begin
            v = {$urandom, $urandom};
            v = (v <<< 22) >>> 22;
         end
      endcase
      return v;
   endfunction

   initial begin
      int held;
      vt[0] = '{0, 64'sh30000, 16'h0002};
      vt[1] = '{0, 64'sh10000, 16'h0000};
      vt[2] = '{0, 64'sh50000, 16'h0002};
      vt[3] = '{0, -64'sh30000, 16'hFFFE};
      vt[4] = '{0, 64'sh10001, 16'h0001};
      vt[5] = '{2, 64'sh1_0000_0000, 16'h7FFF};
      vt[6] = '{3, -64'sh2_0000_0000, 16'h8000};

      rst = 1'b1; req_valid = 4'hF; req_data = '0; out_ready = 1'b1; clr = 1'b0;
      tick();
      tick();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_data", 64'(out_data), 64'h0);
      chk("rst_ch", 64'(out_ch), 64'h0);
      chk("rst_cnt", sat_cnt, 64'h0);
      chk("rst_sticky", 64'(sticky), 64'h0);
      rst = 1'b0; req_valid = '0;
      #1;
      chk("rel_ready", 64'(req_ready), 64'hF);

      for (int i = 0; i < 7; i++) begin
         set_ch(vt[i].ch, vt[i].din);
         req_valid = 4'(1 << vt[i].ch);
         tick();
         chk($sformatf("v%0d_valid_early", i), 64'(out_valid), 64'h0);
         chk($sformatf("v%0d_ready_busy", i), 64'(req_ready[vt[i].ch]), 64'h0);
         req_valid = '0;
         tick();
         chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
         chk($sformatf("v%0d_data", i), 64'(out_data), 64'(vt[i].exp));
         chk($sformatf("v%0d_ch", i), 64'(out_ch), 64'(vt[i].ch));
         check_all();
         tick();
      end
      chk("sat_cnt_vec", sat_cnt, 64'h0001_0001_0000_0000);
      chk("sat_sticky_vec", 64'(sticky), 64'hC);

      req_valid = 4'hF;
      for (int c = 0; c < NCH; c++) set_ch(c, rnd_acc());
      tick();
      for (int n = 0; n < 16; n++) begin
         for (int c = 0; c < NCH; c++) set_ch(c, rnd_acc());
         tick();
         chk("fair_valid", 64'(out_valid), 64'h1);
         chk("fair_ch", 64'(out_ch), 64'(n % NCH));
         check_all();
      end

      out_ready = 1'b0;
      held = m_och;
      for (int n = 0; n < 5; n++) begin
         for (int c = 0; c < NCH; c++) set_ch(c, rnd_acc());
         tick();
         chk("bp_ch_hold", 64'(out_ch), 64'(held));
         check_all();
      end
      chk("bp_ready_all0", 64'(req_ready), 64'h0);
      out_ready = 1'b1; req_valid = '0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (n < 4) chk("drain_ch", 64'(out_ch), 64'((held + 1 + n) % NCH));
         check_all();
      end

      set_ch(1, 64'sh1_0000_0000);
      req_valid = 4'b0010;
      tick();
      req_valid = '0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_cnt", sat_cnt, 64'h0000_0000_0001_0000);
      chk("clr_sticky", 64'(sticky), 64'h2);
      check_all();

      set_ch(0, -64'sh3_0000_0000);
      req_valid = 4'b0001;
      for (int n = 0; n < 20; n++) begin
         tick();
         check_all();
      end
      req_valid = '0;
      tick();
      chk("cnt3b_hold", 64'(sat_cnt2[2:0]), 64'h7);
      chk("cnt16_ch0", 64'(sat_cnt[15:0]), 64'(m_cnt[0]));

      for (int c = 0; c < 600; c++) begin
         rst = (c >= 300 && c < 302);
         req_valid = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 31) == 0);
         for (int k = 0; k < NCH; k++) set_ch(k, rnd_acc());
         tick();
         check_all();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
